// File: rtl/posit_to_fixed_stream.sv
// Iterative posit8 (es=0) to exact signed fixed-point converter with valid/ready
// handshakes. The regime is scanned one bit per cycle, so latency depends on the input.
module posit_to_fixed_stream #(
    parameter int FRAC_W = 8,
    parameter int INT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [7:0]                in_posit,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INT_W+FRAC_W-1:0]   out_fix,
    output logic                      out_zero,
    output logic                      out_nar
);

    localparam int W = INT_W + FRAC_W;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SCAN     = 2'd1,
        ST_ASSEMBLE = 2'd2,
        ST_OUT      = 2'd3
    } state_t;

    state_t         state_q;
    logic           s_q;
    logic [6:0]     p_q;
    logic           rc_q;
    logic [2:0]     r_q;
    logic [2:0]     i_q;
    logic           out_valid_q;
    logic [W-1:0]   out_fix_q;
    logic           out_zero_q;
    logic           out_nar_q;

    logic [6:0]     p_d;
    logic [5:0]     frac_d;
    logic [12:0]    mant_d;
    logic [12:0]    scaled_d;
    logic [W-1:0]   mag_d;
    logic [W-1:0]   fix_d;

    // Negative posits are decoded from their two's-complement magnitude.
    assign p_d = in_posit[7] ? 7'(~in_posit[6:0] + 7'd1) : in_posit[6:0];

    // NOTE: every always_comb output gets a default on every path, so no latch is inferred.
    always_comb begin
        frac_d   = 6'(p_q << r_q);
        mant_d   = {6'd0, 1'b1, frac_d};
        // scaled_d holds value * 2^6, always an integer since the finest posit step is 2^-6.
        scaled_d = rc_q ? (mant_d << (r_q - 3'd1)) : (mant_d >> r_q);
        mag_d    = W'(scaled_d) << (FRAC_W - 6);
        fix_d    = s_q ? (~mag_d + W'(1)) : mag_d;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            s_q         <= 1'b0;
            p_q         <= '0;
            rc_q        <= 1'b0;
            r_q         <= '0;
            i_q         <= '0;
            out_valid_q <= 1'b0;
            out_fix_q   <= '0;
            out_zero_q  <= 1'b0;
            out_nar_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        s_q  <= in_posit[7];
                        p_q  <= p_d;
                        rc_q <= p_d[6];
                        r_q  <= 3'd1;
                        i_q  <= 3'd5;
                        if (p_d == 7'd0) begin
                            state_q     <= ST_OUT;
                            out_valid_q <= 1'b1;
                            out_zero_q  <= ~in_posit[7];
                            out_nar_q   <= in_posit[7];
                            out_fix_q   <= in_posit[7] ? {1'b1, {(W-1){1'b0}}} : '0;
                        end else begin
                            state_q <= ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (p_q[i_q] == rc_q) begin
                        r_q <= r_q + 3'd1;
                        if (i_q == 3'd0) begin
                            state_q <= ST_ASSEMBLE;
                        end else begin
                            i_q <= i_q - 3'd1;
                        end
                    end else begin
                        state_q <= ST_ASSEMBLE;
                    end
                end
                ST_ASSEMBLE: begin
                    out_fix_q   <= fix_d;
                    out_zero_q  <= 1'b0;
                    out_nar_q   <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_fix   = out_fix_q;
    assign out_zero  = out_zero_q;
    assign out_nar   = out_nar_q;

endmodule

// File: tb/tb_posit_to_fixed_stream.sv
// Directed and exhaustive checks of posit_to_fixed_stream at default widths (Q8.8),
// with expected values from an exact-value posit8 reference model.
module tb_posit_to_fixed_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_posit;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_fix;
    logic        out_zero;
    logic        out_nar;

    int n_checks = 0;
    int n_errors = 0;

    posit_to_fixed_stream #(.FRAC_W(8), .INT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_posit  (in_posit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fix   (out_fix),
        .out_zero  (out_zero),
        .out_nar   (out_nar)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Value * 2^8 as 2^nf+frac scaled by a power of two; also the expected latency.
    task automatic model(input logic [7:0] c, output logic [15:0] fix, output logic z,
                         output logic n, output int lat);
        logic [7:0] mag;
        int run, k, nf, frac, val;
        bit b, done;
        fix = 16'h0; z = 1'b0; n = 1'b0; lat = 1;
        if (c == 8'h00) begin
            z = 1'b1;
        end else if (c == 8'h80) begin
            n = 1'b1;
            fix = 16'h8000;
        end else begin
            mag = c[7] ? 8'(-c) : c;
            b = mag[6];
            run = 0;
            done = 1'b0;
            for (int j = 6; j >= 0; j--) begin
                if (!done && mag[j] == b) run++;
                else done = 1'b1;
            end
            k = b ? run - 1 : -run;
            nf = (run >= 6) ? 0 : 6 - run;
            frac = int'(mag) & ((1 << nf) - 1);
            val = ((1 << nf) + frac) << (k + 8 - nf);
            fix = c[7] ? 16'(-val) : 16'(val);
            lat = ((run < 6) ? run : 6) + 2;
        end
    endtask

    // One conversion; out_ready is held low for `hold` cycles once the result is valid.
    task automatic run(input logic [7:0] code, input int hold);
        logic [15:0] e_fix;
        logic e_z, e_n;
        int e_lat, lat;
        string t;
        model(code, e_fix, e_z, e_n, e_lat);
        t = $sformatf("%02h", code);
        @(negedge clk);
        out_ready = (hold == 0);
        in_posit  = code;
        in_valid  = 1'b1;
        check({t, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_posit = 8'hxx;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({t, " out_valid"}, 32'(out_valid), 32'd1);
        check({t, " latency"}, 32'(lat), 32'(e_lat));
        check({t, " out_fix"}, 32'(out_fix), 32'(e_fix));
        check({t, " out_zero"}, 32'(out_zero), 32'(e_z));
        check({t, " out_nar"}, 32'(out_nar), 32'(e_n));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({t, " held valid"}, 32'(out_valid), 32'd1);
            check({t, " held fix"}, 32'(out_fix), 32'(e_fix));
            check({t, " held in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({t, " ready after"}, 32'(in_ready), 32'd1);
        check({t, " valid after"}, 32'(out_valid), 32'd0);
    endtask

    logic [7:0] directed [10] = '{8'h40, 8'h50, 8'h60, 8'h7F, 8'h01,
                                  8'hC0, 8'hB0, 8'h81, 8'h00, 8'h80};

    initial begin
        bit seen;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_posit  = 8'h40;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_fix", 32'(out_fix), 32'd0);
        check("reset flags", 32'({out_zero, out_nar}), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (directed[d]) run(directed[d], 0);

        run(8'h50, 5);
        run(8'hB0, 5);

        // Abort a long conversion mid-scan with a one-cycle reset.
        @(negedge clk);
        in_posit = 8'h7F;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("abort no output", 32'(seen), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        run(8'h40, 0);

        for (int c = 0; c < 256; c++) run(8'(c), int'($urandom_range(0, 2)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/posit_to_fixed_stream.md
# posit_to_fixed_stream

Sequential decoder that converts an 8-bit posit (es=0, the format produced by the MAC datapath encoder) into an exact signed fixed-point value. It sits on the output side of the posit MAC, with valid/ready handshakes on both input and output. Regime decoding is iterative: one regime bit is scanned per cycle, so latency depends on the input. Every posit8 value is represented exactly, so no rounding is performed.

## Interface
- `FRAC_W`, default 8: fractional bits of the output. Must be ≥ 6.
- `INT_W`, default 8: integer bits of the output, including the sign bit. Must be ≥ 8.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: reset. Synchronous, active-low.
- `in_valid` input 1: `in_posit` is valid.
- `in_ready` output 1: block can accept an input. High only in IDLE.
- `in_posit` input 8: posit8 to convert, es=0.
- `out_valid` output 1: result is valid. Held until it is accepted.
- `out_ready` input 1: downstream accepts the result.
- `out_fix` output `INT_W+FRAC_W`: signed two's-complement result, Q(`INT_W`).(`FRAC_W`).
- `out_zero` output 1: the input was 0x00.
- `out_nar` output 1: the input was NaR (0x80).

## Operation
- **States:** IDLE, SCAN, ASSEMBLE, OUT.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, register the sign `s`=`in_posit[7]`.
  - Register the payload `p` = `s` ? (~`in_posit[6:0]`+1)[6:0] : `in_posit[6:0]`.
  - Set `rc`=`p[6]`, run count `r`=1, bit pointer `i`=5.
  - If the payload is zero, go to OUT with the special result. Otherwise go to SCAN.
- **SCAN:** one bit per cycle.
  - If `p[i]`==`rc`: `r`++, `i`--.
  - Leave for ASSEMBLE when `p[i]`≠`rc` (terminator found) or when `i`==0 has been examined.
  - Number of SCAN cycles = min(`r`,6).
- **ASSEMBLE:** one cycle.
  - `k` = `rc` ? `r`−1 : −`r`.
  - Fraction = the 6−`r` bits below the terminator (none if `r`≥6).
  - Mantissa `m` = {1, fraction, zero-pad} as a 7-bit value with 6 fractional bits.
  - Magnitude = `m` << (`k`+`FRAC_W`−6). The shift is always ≥ 0.
  - `out_fix` = `s` ? −magnitude : magnitude. Go to OUT.
- **OUT**
  - `out_valid`=1. `out_fix` and the flags are stable.
  - On `out_valid`&`out_ready`, go to IDLE.
- **Special results**
  - Zero: `out_fix`=0, `out_zero`=1, `out_nar`=0.
  - NaR: `out_fix`=most-negative value (0x8000 at default widths), `out_nar`=1, `out_zero`=0.
- **Flags:** `out_zero` and `out_nar` are 0 for all other inputs.
- **Occupancy:** one conversion in flight. No new input is accepted in SCAN, ASSEMBLE or OUT.
- **Range:** value range is ±[2^-6, 64]. The default 16-bit output holds this range exactly; maximum magnitude is 0x4000.

## Timing
- **Reset:** on a rising edge with `rst_n`=0 the block goes to IDLE and clears `out_valid`, `out_fix`, `out_zero`, `out_nar` and all internal registers to 0.
  - `in_ready` reads 1 from the first cycle after reset.
  - A handshake in a cycle where `rst_n`=0 is ignored.
  - Reset during SCAN, ASSEMBLE or OUT aborts the conversion, and no output is produced for it.
- **Latency** from the accept edge to the first cycle with `out_valid` high:
  - min(`r`,6)+2 cycles for normal inputs.
  - 1 cycle for zero and NaR.
- **Return to IDLE:** `in_ready` returns high in the cycle after the output handshake. Back-to-back throughput is therefore latency+1 cycles minimum.
- **Backpressure:** `out_ready` held low keeps OUT indefinitely, with all outputs unchanged.
- **Ignored inputs:** `in_valid` and `in_posit` are ignored outside IDLE. `out_ready` is ignored outside OUT.

## Test plan
- **Reset:** reset, then `in_posit`=0x40, `out_ready`=1 → `out_fix`=0x0100, `out_valid` 3 cycles after accept, `in_ready` high again the next cycle.
- **Positive values:**
  - 0x50 → 0x0180 (1.5), latency 3.
  - 0x60 → 0x0200, latency 4.
  - 0x7F → 0x4000, latency 8.
  - 0x01 → 0x0004, latency 8.
- **Negative values:** 0xC0 → 0xFF00. 0xB0 → 0xFE80 (−1.5). 0x81 → 0xC000 (−64). Sign flags are 0.
- **Specials:**
  - 0x00 → `out_fix`=0, `out_zero`=1, latency 1.
  - 0x80 → `out_fix`=0x8000, `out_nar`=1, latency 1.
- **Backpressure:** `out_ready`=0 for 5 cycles in OUT → `out_valid` and `out_fix` stable and `in_ready`=0 throughout. Raise `out_ready` → IDLE on the next cycle.
- **Abort:** assert `rst_n`=0 for one cycle during SCAN of 0x7F → `out_valid` never rises for it. A following 0x40 converts to 0x0100.
- **Sweep:** all 256 codes back-to-back with random `out_ready` → every result matches the exact-value reference model.
